// File: rtl/simd_fetch_ctrl_if.sv
// Instruction-fetch bus bundle for simd_fetch_ctrl.
// Carries two channels:
//   instruction BRAM read port : ins_addr, ins_en (to BRAM), ins_rdata (from BRAM, 1-cycle latency)
//   decoder issue handshake    : issue_valid, issue_ins (to decoder), issue_ready (from decoder)
// Modports:
//   master : the fetch controller side
//   slave  : the BRAM / decoder side
interface simd_fetch_ctrl_if #(
    parameter int INS_ADDR_WIDTH = 11,
    parameter int INS_WIDTH      = 64
);
    logic [INS_ADDR_WIDTH-1:0] ins_addr;
    logic                      ins_en;
    logic [INS_WIDTH-1:0]      ins_rdata;
    logic                      issue_valid;
    logic                      issue_ready;
    logic [INS_WIDTH-1:0]      issue_ins;

    modport master (
        output ins_addr, ins_en, issue_valid, issue_ins,
        input  ins_rdata, issue_ready
    );

    modport slave (
        input  ins_addr, ins_en, issue_valid, issue_ins,
        output ins_rdata, issue_ready
    );
endinterface

// File: rtl/simd_fetch_ctrl.sv
// simd_fetch_ctrl: instruction sequencer for the 4-PE SIMD processor.
// Fetches 64-bit instructions from the instruction BRAM, resolves JMP and HALT
// locally and issues every other instruction to the decoder over valid/ready,
// honouring the global stall.
//
// Ports:
//   clk, rstn        clock (posedge) and asynchronous active-low reset
//   start/start_addr 1-cycle start pulse and first instruction address
//   stall            global stall: blocks fetch and issue
//   busy             high from accepted start until the HALT is retired
//   done             1-cycle pulse when HALT is retired
//   bus (master)     BRAM read port (ins_addr/ins_en/ins_rdata) and
//                    issue handshake (issue_valid/issue_ready/issue_ins)
//   issued_cnt, stall_cnt  performance counters, present only with FETCH_PERF_CNT_EN
//
// Build option: define FETCH_PERF_CNT_EN to add the performance counters.
//
// state   | meaning
// --------+-----------------------------------------------------------
// S_IDLE  | waiting for start
// S_FETCH | drive BRAM read at pc (held while stalled)
// S_WAIT  | BRAM data arriving; decode JMP / HALT / issuable instruction
// S_ISSUE | issue_valid high until accepted without stall
// S_DONE  | HALT retired: pulse done, drop busy
module simd_fetch_ctrl #(
    parameter int                   INS_ADDR_WIDTH = 11,
    parameter int                   INS_WIDTH      = 64,
    parameter int                   OPC_WIDTH      = 4,
    parameter logic [OPC_WIDTH-1:0] OPC_JMP        = 4'hE,
    parameter logic [OPC_WIDTH-1:0] OPC_HALT       = 4'hF
) (
    input  logic                      clk,
    input  logic                      rstn,
    input  logic                      start,
    input  logic [INS_ADDR_WIDTH-1:0] start_addr,
    input  logic                      stall,
    output logic                      busy,
    output logic                      done,
`ifdef FETCH_PERF_CNT_EN
    output logic [31:0]               issued_cnt,
    output logic [31:0]               stall_cnt,
`endif
    simd_fetch_ctrl_if.master         bus
);

    typedef enum logic [2:0] {S_IDLE, S_FETCH, S_WAIT, S_ISSUE, S_DONE} state_t;

    state_t                    state_q, state_d;
    logic [INS_ADDR_WIDTH-1:0] pc_q, pc_d;
    logic [INS_WIDTH-1:0]      issue_ins_q, issue_ins_d;
    logic                      issue_valid_q, issue_valid_d;
    logic                      busy_q, busy_d;
    logic                      done_q, done_d;
    logic                      ins_en;
    logic                      fire;
    logic                      start_acc;
    logic [OPC_WIDTH-1:0]      opc;

    assign opc = bus.ins_rdata[INS_WIDTH-1 -: OPC_WIDTH];

    always_comb begin
        state_d       = state_q;
        pc_d          = pc_q;
        issue_ins_d   = issue_ins_q;
        issue_valid_d = issue_valid_q;
        busy_d        = busy_q;
        done_d        = 1'b0;
        ins_en        = 1'b0;
        fire          = 1'b0;
        start_acc     = 1'b0;
        case (state_q)
            S_IDLE: begin
                // stall does not block acceptance of start
                if (start) begin
                    start_acc = 1'b1;
                    pc_d      = start_addr;
                    busy_d    = 1'b1;
                    state_d   = S_FETCH;
                end
            end
            S_FETCH: begin
                if (!stall) begin
                    ins_en  = 1'b1;
                    state_d = S_WAIT;
                end
            end
            S_WAIT: begin
                // read data is only valid this one cycle, so it is consumed
                // regardless of stall; stall is applied again in FETCH/ISSUE
                if (opc == OPC_JMP) begin
                    pc_d    = bus.ins_rdata[INS_ADDR_WIDTH-1:0];
                    state_d = S_FETCH;
                end else if (opc == OPC_HALT) begin
                    done_d  = 1'b1;
                    state_d = S_DONE;
                end else begin
                    issue_ins_d   = bus.ins_rdata;
                    issue_valid_d = 1'b1;
                    state_d       = S_ISSUE;
                end
            end
            S_ISSUE: begin
                fire = issue_valid_q & bus.issue_ready & ~stall;
                if (fire) begin
                    issue_valid_d = 1'b0;
                    pc_d          = pc_q + 1'b1;   // wraps modulo the BRAM depth
                    state_d       = S_FETCH;
                end
            end
            S_DONE: begin
                busy_d  = 1'b0;
                state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q       <= S_IDLE;
            pc_q          <= '0;
            issue_ins_q   <= '0;
            issue_valid_q <= 1'b0;
            busy_q        <= 1'b0;
            done_q        <= 1'b0;
        end else begin
            state_q       <= state_d;
            pc_q          <= pc_d;
            issue_ins_q   <= issue_ins_d;
            issue_valid_q <= issue_valid_d;
            busy_q        <= busy_d;
            done_q        <= done_d;
        end
    end

    // pc is only changed outside FETCH, so it doubles as the registered BRAM address
    assign bus.ins_addr    = pc_q;
    assign bus.ins_en      = ins_en;
    assign bus.issue_valid = issue_valid_q;
    assign bus.issue_ins   = issue_ins_q;
    assign busy            = busy_q;
    assign done            = done_q;

`ifdef FETCH_PERF_CNT_EN
    logic [31:0] issued_cnt_q, stall_cnt_q;

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            issued_cnt_q <= '0;
            stall_cnt_q  <= '0;
        end else if (start_acc) begin
            issued_cnt_q <= '0;
            stall_cnt_q  <= '0;
        end else begin
            if (fire && issued_cnt_q != 32'hFFFF_FFFF)
                issued_cnt_q <= issued_cnt_q + 32'd1;
            if (busy_q && stall && stall_cnt_q != 32'hFFFF_FFFF)
                stall_cnt_q <= stall_cnt_q + 32'd1;
        end
    end

    assign issued_cnt = issued_cnt_q;
    assign stall_cnt  = stall_cnt_q;
`endif

endmodule

// File: tb/tb_simd_fetch_ctrl.sv
// Testbench for simd_fetch_ctrl: BRAM model, program vector table, and a
// scoreboard of expected fetch addresses and issued instructions.
module tb_simd_fetch_ctrl;
    localparam int AW = 11;
    localparam int DW = 64;

    localparam logic [63:0] I_ADD  = 64'h1000_0000_0000_00A1;
    localparam logic [63:0] I_SUB  = 64'h2000_0000_0000_00B2;
    localparam logic [63:0] I_NOP  = 64'h0000_0000_0000_0C03;
    localparam logic [63:0] I_HALT = 64'hF000_0000_0000_0000;
    localparam logic [63:0] I_J10  = 64'hE000_0000_0000_0010;
    localparam logic [63:0] I_J30  = 64'hE000_0000_0000_0030;

    typedef struct {
        logic [AW-1:0]       start_addr;
        int                  n_prog;
        logic [3:0][AW-1:0]  p_addr;
        logic [3:0][63:0]    p_data;
        int                  n_fetch;
        logic [3:0][AW-1:0]  exp_fetch;
        int                  n_issue;
        logic [3:0][63:0]    exp_issue;
        int                  exp_first_valid;
        int                  exp_done;
        bit                  start_stall;
        int                  restart_cyc;
    } vec_t;

    logic          clk = 1'b0;
    logic          rstn = 1'b0;
    logic          start = 1'b0;
    logic [AW-1:0] start_addr = '0;
    logic          stall = 1'b0;
    logic          busy, done;
`ifdef FETCH_PERF_CNT_EN
    logic [31:0]   issued_cnt, stall_cnt;
`endif

    simd_fetch_ctrl_if #(.INS_ADDR_WIDTH(AW), .INS_WIDTH(DW)) bus ();

    simd_fetch_ctrl dut (
        .clk        (clk),
        .rstn       (rstn),
        .start      (start),
        .start_addr (start_addr),
        .stall      (stall),
        .busy       (busy),
        .done       (done),
`ifdef FETCH_PERF_CNT_EN
        .issued_cnt (issued_cnt),
        .stall_cnt  (stall_cnt),
`endif
        .bus        (bus.master)
    );

    always #5 clk = ~clk;

    logic [63:0] mem [0:2047];
    always @(posedge clk) if (bus.ins_en) bus.ins_rdata <= mem[bus.ins_addr];

    int checks = 0;
    int errors = 0;
    int cyc = 10000;
    int restart_at = -1;
    int r_lo = -1, r_hi = -1, s1_lo = -1, s1_hi = -1, s2_lo = -1, s2_hi = -1;
    int done_cnt, done_cyc, first_valid;
    logic [AW-1:0] cur_addr;
    bit cur_start_stall;
    bit prev_valid, prev_fire;
    logic [63:0] prev_ins;
    logic [63:0] exp_issue_q [$];
    logic [AW-1:0] exp_fetch_q [$];
    vec_t vecs [4];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic fail(input string name, input logic [63:0] act);
        checks++;
        errors++;
        $display("FAIL %s: got 0x%0h, expected nothing (cycle %0d)", name, act, cyc);
    endtask

    // one clock cycle: drive inputs at negedge, sample outputs 1 time unit later
    task automatic step();
        bit fire;
        @(negedge clk);
        start      = (cyc == 0) || (cyc == restart_at);
        start_addr = (cyc == 0) ? cur_addr : 11'h155;
        stall      = (cyc == 0) ? cur_start_stall :
                     ((cyc >= s1_lo && cyc <= s1_hi) || (cyc >= s2_lo && cyc <= s2_hi));
        bus.issue_ready = !(cyc >= r_lo && cyc <= r_hi);
        #1;
        fire = bus.issue_valid && bus.issue_ready && !stall;
        if (prev_valid && !prev_fire) begin
            chk("hold_valid", 64'(bus.issue_valid), 64'd1);
            chk("hold_ins", bus.issue_ins, prev_ins);
        end
        if (stall) chk("ins_en_in_stall", 64'(bus.ins_en), 64'd0);
        if (bus.ins_en) begin
            if (exp_fetch_q.size() == 0) fail("extra_fetch", 64'(bus.ins_addr));
            else chk("fetch_addr", 64'(bus.ins_addr), 64'(exp_fetch_q.pop_front()));
        end
        if (fire) begin
            if (exp_issue_q.size() == 0) fail("extra_issue", bus.issue_ins);
            else chk("issue_ins", bus.issue_ins, exp_issue_q.pop_front());
        end
        if (bus.issue_valid && first_valid < 0) first_valid = cyc;
        if (done) begin
            done_cnt++;
            if (done_cyc < 0) done_cyc = cyc;
            chk("busy_at_done", 64'(busy), 64'd1);
        end
        if (cyc == 1) chk("busy_after_start", 64'(busy), 64'd1);
        prev_valid = bus.issue_valid;
        prev_fire  = fire;
        prev_ins   = bus.issue_ins;
        cyc++;
    endtask

    task automatic idle(input int n);
        cyc = 10000;
        prev_valid = 1'b0;
        repeat (n) begin
            step();
            chk("idle_quiet", {62'd0, bus.ins_en, bus.issue_valid}, 64'd0);
        end
    endtask

    task automatic load_vec(input vec_t v);
        for (int a = 0; a < 2048; a++) mem[a] = 64'h0;
        for (int k = 0; k < v.n_prog; k++) mem[v.p_addr[k]] = v.p_data[k];
        exp_fetch_q.delete();
        exp_issue_q.delete();
        for (int k = 0; k < v.n_fetch; k++) exp_fetch_q.push_back(v.exp_fetch[k]);
        for (int k = 0; k < v.n_issue; k++) exp_issue_q.push_back(v.exp_issue[k]);
        cur_addr = v.start_addr;
        cur_start_stall = v.start_stall;
        restart_at = v.restart_cyc;
        cyc = 0;
        done_cnt = 0;
        done_cyc = -1;
        first_valid = -1;
        prev_valid = 1'b0;
        prev_fire = 1'b0;
    endtask

    task automatic run_vec(input vec_t v);
        load_vec(v);
        while (done_cnt == 0 && cyc < 200) step();
        if (done_cnt == 0) fail("done_timeout", 64'(cyc));
        chk("done_cycle", 64'(done_cyc), 64'(v.exp_done));
        chk("first_valid_cycle", 64'(first_valid), 64'(v.exp_first_valid));
        step();
        chk("busy_after_done", 64'(busy), 64'd0);
        chk("done_one_cycle", 64'(done), 64'd0);
        chk("done_pulses", 64'(done_cnt), 64'd1);
        chk("fetches_left", 64'(exp_fetch_q.size()), 64'd0);
        chk("issues_left", 64'(exp_issue_q.size()), 64'd0);
        restart_at = -1;
        r_lo = -1; r_hi = -1; s1_lo = -1; s1_hi = -1; s2_lo = -1; s2_hi = -1;
    endtask

    initial begin
        vec_t t;
        bus.issue_ready = 1'b1;

        for (int i = 0; i < 4; i++) begin
            vecs[i] = '{default: 0};
            vecs[i].restart_cyc = -1;
        end
        // straight-line program: ADD, SUB, HALT
        vecs[0].start_addr = 11'd0;   vecs[0].n_prog = 3;
        vecs[0].p_addr[0] = 11'd0;    vecs[0].p_data[0] = I_ADD;
        vecs[0].p_addr[1] = 11'd1;    vecs[0].p_data[1] = I_SUB;
        vecs[0].p_addr[2] = 11'd2;    vecs[0].p_data[2] = I_HALT;
        vecs[0].n_fetch = 3; vecs[0].exp_fetch[0] = 11'd0; vecs[0].exp_fetch[1] = 11'd1; vecs[0].exp_fetch[2] = 11'd2;
        vecs[0].n_issue = 2; vecs[0].exp_issue[0] = I_ADD; vecs[0].exp_issue[1] = I_SUB;
        vecs[0].exp_first_valid = 3;  vecs[0].exp_done = 9;
        // JMP straight to HALT: nothing issued
        vecs[1].start_addr = 11'd5;   vecs[1].n_prog = 2;
        vecs[1].p_addr[0] = 11'd5;    vecs[1].p_data[0] = I_J10;
        vecs[1].p_addr[1] = 11'h10;   vecs[1].p_data[1] = I_HALT;
        vecs[1].n_fetch = 2; vecs[1].exp_fetch[0] = 11'd5; vecs[1].exp_fetch[1] = 11'h10;
        vecs[1].n_issue = 0;
        vecs[1].exp_first_valid = -1; vecs[1].exp_done = 5;
        // pc wrap 2047 -> 0, with an ignored start while busy
        vecs[2].start_addr = 11'd2047; vecs[2].n_prog = 2;
        vecs[2].p_addr[0] = 11'd2047; vecs[2].p_data[0] = I_NOP;
        vecs[2].p_addr[1] = 11'd0;    vecs[2].p_data[1] = I_HALT;
        vecs[2].n_fetch = 2; vecs[2].exp_fetch[0] = 11'd2047; vecs[2].exp_fetch[1] = 11'd0;
        vecs[2].n_issue = 1; vecs[2].exp_issue[0] = I_NOP;
        vecs[2].exp_first_valid = 3;  vecs[2].exp_done = 6; vecs[2].restart_cyc = 2;
        // issue, jump, issue, halt; start together with stall
        vecs[3].start_addr = 11'h20;  vecs[3].n_prog = 4;
        vecs[3].p_addr[0] = 11'h20;   vecs[3].p_data[0] = I_ADD;
        vecs[3].p_addr[1] = 11'h21;   vecs[3].p_data[1] = I_J30;
        vecs[3].p_addr[2] = 11'h30;   vecs[3].p_data[2] = I_SUB;
        vecs[3].p_addr[3] = 11'h31;   vecs[3].p_data[3] = I_HALT;
        vecs[3].n_fetch = 4; vecs[3].exp_fetch[0] = 11'h20; vecs[3].exp_fetch[1] = 11'h21;
        vecs[3].exp_fetch[2] = 11'h30; vecs[3].exp_fetch[3] = 11'h31;
        vecs[3].n_issue = 2; vecs[3].exp_issue[0] = I_ADD; vecs[3].exp_issue[1] = I_SUB;
        vecs[3].exp_first_valid = 3;  vecs[3].exp_done = 11; vecs[3].start_stall = 1'b1;

        // reset values
        repeat (2) @(negedge clk);
        #1;
        chk("rst_busy", 64'(busy), 64'd0);
        chk("rst_done", 64'(done), 64'd0);
        chk("rst_ins_en", 64'(bus.ins_en), 64'd0);
        chk("rst_ins_addr", 64'(bus.ins_addr), 64'd0);
        chk("rst_issue_valid", 64'(bus.issue_valid), 64'd0);
        chk("rst_issue_ins", bus.issue_ins, 64'd0);
        @(negedge clk);
        rstn = 1'b1;
        idle(3);

        for (int i = 0; i < 4; i++) begin
            run_vec(vecs[i]);
`ifdef FETCH_PERF_CNT_EN
            if (i == 0) chk("issued_cnt_basic", 64'(issued_cnt), 64'd2);
`endif
        end

        // decoder back-pressure: ready low for the first 4 ISSUE cycles
        t = vecs[0];
        t.exp_done = 13;
        r_lo = 3; r_hi = 6;
        run_vec(t);

        // 39 stall cycles: 20 in FETCH, 19 in ISSUE
        t = vecs[0];
        t.exp_first_valid = 23;
        t.exp_done = 48;
        s1_lo = 1; s1_hi = 20; s2_lo = 23; s2_hi = 41;
        run_vec(t);
`ifdef FETCH_PERF_CNT_EN
        chk("stall_cnt", 64'(stall_cnt), 64'd39);
        chk("issued_cnt_stall", 64'(issued_cnt), 64'd2);
`endif

        // reset while in ISSUE, then rerun from scratch
        load_vec(vecs[0]);
        repeat (4) step();
        chk("pre_rst_valid", 64'(bus.issue_valid), 64'd1);
        rstn = 1'b0;
        #1;
        chk("mid_rst_valid", 64'(bus.issue_valid), 64'd0);
        chk("mid_rst_ins", bus.issue_ins, 64'd0);
        chk("mid_rst_busy", 64'(busy), 64'd0);
        chk("mid_rst_ins_en", 64'(bus.ins_en), 64'd0);
        chk("mid_rst_ins_addr", 64'(bus.ins_addr), 64'd0);
`ifdef FETCH_PERF_CNT_EN
        chk("mid_rst_issued_cnt", 64'(issued_cnt), 64'd0);
`endif
        @(negedge clk);
        rstn = 1'b1;
        exp_fetch_q.delete();
        exp_issue_q.delete();
        idle(5);
        run_vec(vecs[0]);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: got time %0t, expected finish earlier", $time);
        $fatal(1, "timeout");
    end
endmodule
